// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types and constants.
// FSM state encoding, frame geometry and parameter defaults.
package ps2_pkg;

  localparam int DATA_BITS          = 8;
  localparam int FRAME_BITS         = 11;
  localparam int FILTER_CYCLES_DEF  = 8;
  localparam int TIMEOUT_CYCLES_DEF = 100000;
  localparam int FIFO_DEPTH_DEF     = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } ps2_state_t;

  // Odd parity holds when data plus parity bit has an odd count of ones.
  function automatic logic odd_par_ok(
    input logic [DATA_BITS-1:0] d,
    input logic                 p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchroniser plus stable-count glitch filter.
// Emits a one-cycle pulse on each filtered 1->0 transition.
module ps2_input_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_filt;
  logic          r_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_fall <= 1'b0;
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
        r_fall <= r_filt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver with scancode FIFO.
// Decodes start/8 data/odd parity/stop frames on filtered clock edges.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = FILTER_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  input  logic       scancode_ready,
  output logic       frame_error,
  output logic       overflow,
  input  logic       clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic w_fall;
  logic w_dat;

  ps2_input_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filt (
    .clk   (clk),
    .reset (reset),
    .i_raw (PS2_CLK),
    .o_fall(w_fall)
  );

  logic [1:0] r_dsync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_dsync <= 2'b11;
    else        r_dsync <= {r_dsync[0], PS2_DAT};
  end

  assign w_dat = r_dsync[1];

  ps2_state_t          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]          r_bitcnt;
  logic                r_par_ok;
  logic [TW-1:0]       r_tmo;
  logic                r_ferr;

  logic w_push;
  logic w_tmo;

  assign w_push = (r_state == S_STOP) && w_fall
                && w_dat && r_par_ok;
  assign w_tmo  = (r_state != S_IDLE) && !w_fall
                && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par_ok <= 1'b0;
      r_tmo    <= '0;
      r_ferr   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (r_state == S_IDLE || w_fall) r_tmo <= '0;
      else                             r_tmo <= r_tmo + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_fall && !w_dat) begin
            r_state  <= S_DATA;
            r_bitcnt <= '0;
            r_shift  <= '0;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_shift  <= {w_dat, r_shift[DATA_BITS-1:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'(DATA_BITS - 1))
              r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (w_fall) begin
            r_par_ok <= odd_par_ok(r_shift, w_dat);
            r_state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_state <= S_IDLE;
            if (!(w_dat && r_par_ok)) r_ferr <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Silent bus mid-frame: abandon the partial byte.
      if (w_tmo) begin
        r_state  <= S_IDLE;
        r_ferr   <= 1'b1;
        r_tmo    <= '0;
        r_bitcnt <= '0;
        r_shift  <= '0;
      end
    end
  end

  assign frame_error = r_ferr;

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic        r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_ovf;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW])
                && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = !w_empty && scancode_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_ovf   = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp[AW-1:0]] <= r_shift;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_ovf)               r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;
    end
  end

  assign scancode       = r_mem[r_rp[AW-1:0]];
  assign scancode_valid = !w_empty;
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_ps2_receiver.sv
// Randomised bench for ps2_receiver against a frame-level model.
// Model decides each frame's fate from the bits sent on the wire.
module tb_ps2_receiver;

  localparam int FILT = 8;
  localparam int TMO  = 1000;
  localparam int DEP  = 4;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       scancode_ready = 1'b0;
  logic       frame_error;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  ps2_receiver #(
    .FILTER_CYCLES (FILT),
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH    (DEP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .PS2_CLK       (PS2_CLK),
    .PS2_DAT       (PS2_DAT),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .scancode_ready(scancode_ready),
    .frame_error   (frame_error),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] q[$];
  logic [7:0] popped[$];
  bit         m_ovf = 1'b0;
  int         m_err = 0;
  int         err_seen = 0;
  logic [7:0] exp_b;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (frame_error) err_seen++;
      if (scancode_valid && scancode_ready) begin
        n_tests++;
        popped.push_back(scancode);
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_model_empty: got %02h expected none", scancode);
        end else begin
          exp_b = q.pop_front();
          if (scancode !== exp_b) begin
            n_fail++;
            $display("FAIL pop_data: got %02h expected %02h", scancode, exp_b);
          end
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(logic b);
    PS2_DAT = b;
    cyc(HALF);
    PS2_CLK = 1'b0;
    cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, bit par_flip, bit stop_b);
    logic p;
    p = ~^d ^ par_flip;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(stop_b);
    PS2_DAT = 1'b1;
    cyc(HALF + 20);
    if (!par_flip && stop_b) begin
      if (q.size() < DEP) q.push_back(d);
      else                m_ovf = 1'b1;
    end else begin
      m_err++;
    end
  endtask

  task automatic send_partial(logic [7:0] d, int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_valid"}, scancode_valid, q.size() != 0);
    if (q.size() != 0) check({tag, "_head"}, scancode, q[0]);
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_errs"}, err_seen, m_err);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) begin
      scancode_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    scancode_ready = 1'b0;
    cyc(1);
    check("drain_empty", scancode_valid, 1'b0);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_valid"}, scancode_valid, 1'b0);
    check({tag, "_code"}, scancode, 8'h00);
    check({tag, "_ferr"}, frame_error, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
  endtask

  initial begin
    cyc(5);
    check_reset_vals("reset");
    reset = 1'b1;
    cyc(10);

    send_frame(8'hF0, 1'b0, 1'b1);
    check_quiet("f0");
    check("f0_lit", scancode, 8'hF0);
    check("f0_noerr", err_seen, 0);
    drain();

    send_frame(8'h1A, 1'b1, 1'b1);
    check("par_err_lit", err_seen, 1);
    check_quiet("par_err");
    send_frame(8'h1A, 1'b0, 1'b1);
    check("par_ok_lit", scancode, 8'h1A);
    check_quiet("par_ok");
    drain();

    PS2_DAT = 1'b0;
    PS2_CLK = 1'b0;
    cyc(3);
    PS2_CLK = 1'b1;
    cyc(30);
    PS2_DAT = 1'b1;
    cyc(20);
    send_frame(8'h5A, 1'b0, 1'b1);
    check("glitch_lit", scancode, 8'h5A);
    check_quiet("glitch");
    drain();

    send_partial(8'h1C, 4);
    PS2_DAT = 1'b1;
    cyc(TMO + 200);
    m_err++;
    check_quiet("timeout");
    send_frame(8'h1C, 1'b0, 1'b1);
    check("after_tmo_lit", scancode, 8'h1C);
    check_quiet("after_tmo");
    drain();

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
    check("ovf_lit", overflow, 1'b1);
    check("ovf_head_lit", scancode, 8'h01);
    check_quiet("ovf");
    popped.delete();
    drain();
    check("ovf_npop", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      check("ovf_order", popped[i], 8'(i + 1));
    clear_overflow = 1'b1;
    cyc(1);
    clear_overflow = 1'b0;
    m_ovf = 1'b0;
    check("ovf_clear", overflow, 1'b0);

    send_frame(8'h33, 1'b0, 1'b1);
    send_partial(8'h77, 5);
    PS2_DAT = 1'b0;
    cyc(10);
    reset = 1'b0;
    cyc(3);
    check_reset_vals("mid_reset");
    q.delete();
    m_ovf = 1'b0;
    reset = 1'b1;
    PS2_DAT = 1'b1;
    cyc(50);
    send_frame(8'h29, 1'b0, 1'b1);
    check("post_reset_lit", scancode, 8'h29);
    check_quiet("post_reset");
    drain();

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit pf;
      bit sb;
      d  = 8'($urandom);
      pf = ($urandom_range(0, 4) == 0);
      sb = ($urandom_range(0, 7) != 0);
      send_frame(d, pf, sb);
      check_quiet("rand");
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    check_quiet("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
